// File: rtl/dlx_pkg.sv
// Shared DLX decode constants: opcodes, function codes, ALU operations,
// access sizes and the ID/EX control bundle.
// FP-only opcodes exist only when FPU_REGS_EN is defined.
package dlx_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0,  OP_FTYPE = 6'd1,  OP_J     = 6'd2,  OP_JAL   = 6'd3,
                         OP_BEQZ  = 6'd4,  OP_BNEZ  = 6'd5,  OP_ADDI  = 6'd8,  OP_ADDUI = 6'd9,
                         OP_SUBI  = 6'd10, OP_SUBUI = 6'd11, OP_ANDI  = 6'd12, OP_ORI   = 6'd13,
                         OP_XORI  = 6'd14, OP_LHI   = 6'd15, OP_JR    = 6'd18, OP_JALR  = 6'd19,
                         OP_SLLI  = 6'd20, OP_SRLI  = 6'd22, OP_SRAI  = 6'd23, OP_SEQI  = 6'd24,
                         OP_SNEI  = 6'd25, OP_SLTI  = 6'd26, OP_SGTI  = 6'd27, OP_SLEI  = 6'd28,
                         OP_SGEI  = 6'd29, OP_LB    = 6'd32, OP_LH    = 6'd33, OP_LW    = 6'd35,
                         OP_LBU   = 6'd36, OP_LHU   = 6'd37, OP_SB    = 6'd40, OP_SH    = 6'd41,
                         OP_SW    = 6'd43;
`ifdef FPU_REGS_EN
  localparam logic [5:0] OP_LF = 6'd38, OP_SF = 6'd46;
  localparam logic [1:0] FILE_FP = 2'b01;
`endif
  localparam logic [1:0] FILE_INT = 2'b00;

  localparam logic [5:0] F_SLL = 6'd4,  F_SRL = 6'd6,  F_SRA = 6'd7,  F_ADD = 6'd32,
                         F_ADDU = 6'd33, F_SUB = 6'd34, F_SUBU = 6'd35, F_AND = 6'd36,
                         F_OR = 6'd37,  F_XOR = 6'd38, F_SEQ = 6'd40, F_SNE = 6'd41,
                         F_SLT = 6'd42, F_SGT = 6'd43, F_SLE = 6'd44, F_SGE = 6'd45;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_SEQ, ALU_SNE, ALU_SLT, ALU_SGT, ALU_SLE, ALU_SGE, ALU_PASSB
  } alu_op_e;

  typedef enum logic [1:0] {DS_BYTE = 2'b00, DS_HALF = 2'b01, DS_WORD = 2'b10} dsize_e;

  typedef struct packed {
    logic       regdst, alusrc, mem2reg, regwrite, memwrite, ex_jump, loadext, jal;
    logic [3:0] aluctrl;
    logic [1:0] fpoint, dsize;
    logic [4:0] rw;
  } ctrl_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  // Loads and stores share the same low-bit size pattern.
  function automatic dsize_e mem_size(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return DS_BYTE;
      OP_LH, OP_LHU, OP_SH: return DS_HALF;
      default:              return DS_WORD;
    endcase
  endfunction

endpackage

// File: rtl/reg_decode_if.sv
// Decode-stage bus: IF/ID inputs, writeback and forwarding inputs,
// early branch resolution and the ID/EX register outputs.
interface reg_decode_if;
  logic        stall;
  logic [31:0] instruction, delayslot, delayslot2_in;
  logic [4:0]  wb_rw;
  logic [31:0] busW;
  logic        wrenable;
  logic [1:0]  wb_fpoint;
  logic [31:0] aluout, dmemout;
  logic [1:0]  fwdA, fwdB;
  logic        branch, jump, jar;
  logic [31:0] branchtarget;
  logic [31:0] instruction_out, delayslot2_out, imm32, busA, busB;
  logic        regdst, alusrc, mem2reg, regwrite, memwrite, ex_jump, loadext, jal;
  logic [3:0]  aluctrl;
  logic [1:0]  fpoint, dsize;
  logic [4:0]  rw;

  modport slave (
    input  stall, instruction, delayslot, delayslot2_in, wb_rw, busW, wrenable, wb_fpoint,
           aluout, dmemout, fwdA, fwdB,
    output branch, jump, jar, branchtarget, instruction_out, delayslot2_out, imm32, busA, busB,
           regdst, alusrc, mem2reg, regwrite, memwrite, ex_jump, loadext, jal,
           aluctrl, fpoint, dsize, rw
  );

  modport master (
    output stall, instruction, delayslot, delayslot2_in, wb_rw, busW, wrenable, wb_fpoint,
           aluout, dmemout, fwdA, fwdB,
    input  branch, jump, jar, branchtarget, instruction_out, delayslot2_out, imm32, busA, busB,
           regdst, alusrc, mem2reg, regwrite, memwrite, ex_jump, loadext, jal,
           aluctrl, fpoint, dsize, rw
  );
endinterface

// File: rtl/reg_file.sv
// 32x32 register file, two combinational read ports with write-through
// bypass, one write port. r0 is hardwired to zero. No reset on contents.
module reg_file (
  input  logic        clock,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  input  logic [4:0]  ra,
  output logic [31:0] rda,
  input  logic [4:0]  rb,
  output logic [31:0] rdb
);
  logic [31:0] mem [32];

  // Write port; r0 is never stored.
  always_ff @(posedge clock)
    if (we && wa != 5'd0) mem[wa] <= wd;

  // Reads see a same-cycle write to the same register.
  always_comb begin
    rda = '0;
    rdb = '0;
    if (ra != 5'd0) rda = (we && wa == ra) ? wd : mem[ra];
    if (rb != 5'd0) rdb = (we && wa == rb) ? wd : mem[rb];
  end
endmodule

// File: rtl/reg_decode.sv
// DLX decode stage: register read with forwarding, immediate generation,
// early branch/jump resolution and the ID/EX pipeline register.
// FPU_REGS_EN adds a second register file for FP operands.
module reg_decode
  import dlx_pkg::*;
(
  input logic         clock,
  input logic         reset,
  reg_decode_if.slave bus
);
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  alu_op_e     f_alu, i_alu;
  logic        f_ok, i_ok;
  ctrl_t       c, ctrl_q;
  logic [31:0] int_a, int_b, rd_a, rd_b, opa, opb, imm, tgt;
  logic [31:0] ins_q, ds2_q, imm_q, a_q, b_q;
  logic        gpr_we;

  assign op    = bus.instruction[31:26];
  assign rs    = bus.instruction[25:21];
  assign rt    = bus.instruction[20:16];
  assign rd    = bus.instruction[15:11];
  assign funct = bus.instruction[5:0];

  assign gpr_we = bus.wrenable && (bus.wb_fpoint == FILE_INT);

  reg_file u_gpr (.clock(clock), .we(gpr_we), .wa(bus.wb_rw), .wd(bus.busW),
                  .ra(rs), .rda(int_a), .rb(rt), .rdb(int_b));

`ifdef FPU_REGS_EN
  logic [31:0] fp_a, fp_b;
  logic        fpr_we;
  assign fpr_we = bus.wrenable && (bus.wb_fpoint == FILE_FP);
  // f0 also reads as zero; the shared register file keeps both files alike.
  reg_file u_fpr (.clock(clock), .we(fpr_we), .wa(bus.wb_rw), .wd(bus.busW),
                  .ra(rs), .rda(fp_a), .rb(rt), .rdb(fp_b));
  assign rd_a = (c.fpoint == FILE_FP) ? fp_a : int_a;
  assign rd_b = (c.fpoint == FILE_FP) ? fp_b : int_b;
`else
  assign rd_a = int_a;
  assign rd_b = int_b;
`endif

  // Forwarding muxes; 11 falls back to the register file.
  always_comb begin
    case (bus.fwdA)
      2'b01:   opa = bus.aluout;
      2'b10:   opa = bus.dmemout;
      default: opa = rd_a;
    endcase
    case (bus.fwdB)
      2'b01:   opb = bus.aluout;
      2'b10:   opb = bus.dmemout;
      default: opb = rd_b;
    endcase
  end

  // R-type function code to ALU operation.
  always_comb begin
    f_ok  = 1'b1;
    f_alu = ALU_ADD;
    case (funct)
      F_ADD, F_ADDU: f_alu = ALU_ADD;
      F_SUB, F_SUBU: f_alu = ALU_SUB;
      F_AND:         f_alu = ALU_AND;
      F_OR:          f_alu = ALU_OR;
      F_XOR:         f_alu = ALU_XOR;
      F_SLL:         f_alu = ALU_SLL;
      F_SRL:         f_alu = ALU_SRL;
      F_SRA:         f_alu = ALU_SRA;
      F_SEQ:         f_alu = ALU_SEQ;
      F_SNE:         f_alu = ALU_SNE;
      F_SLT:         f_alu = ALU_SLT;
      F_SGT:         f_alu = ALU_SGT;
      F_SLE:         f_alu = ALU_SLE;
      F_SGE:         f_alu = ALU_SGE;
      default:       f_ok  = 1'b0;
    endcase
  end

  // Immediate ALU opcode to ALU operation.
  always_comb begin
    i_ok  = 1'b1;
    i_alu = ALU_ADD;
    case (op)
      OP_ADDI, OP_ADDUI: i_alu = ALU_ADD;
      OP_SUBI, OP_SUBUI: i_alu = ALU_SUB;
      OP_ANDI:           i_alu = ALU_AND;
      OP_ORI:            i_alu = ALU_OR;
      OP_XORI:           i_alu = ALU_XOR;
      OP_LHI:            i_alu = ALU_PASSB;
      OP_SLLI:           i_alu = ALU_SLL;
      OP_SRLI:           i_alu = ALU_SRL;
      OP_SRAI:           i_alu = ALU_SRA;
      OP_SEQI:           i_alu = ALU_SEQ;
      OP_SNEI:           i_alu = ALU_SNE;
      OP_SLTI:           i_alu = ALU_SLT;
      OP_SGTI:           i_alu = ALU_SGT;
      OP_SLEI:           i_alu = ALU_SLE;
      OP_SGEI:           i_alu = ALU_SGE;
      default:           i_ok  = 1'b0;
    endcase
  end

  // Main control decode; anything unrecognised stays an all-zero NOP.
  // Non-linking, non-R-type opcodes carry rt in rw even when nothing is written.
  always_comb begin
    c = '0;
    case (op)
      OP_RTYPE, OP_FTYPE: if (f_ok) begin
        c.regdst = 1'b1; c.regwrite = 1'b1; c.aluctrl = f_alu; c.rw = rd;
`ifdef FPU_REGS_EN
        if (op == OP_FTYPE) c.fpoint = FILE_FP;
`endif
      end
      OP_J, OP_JR:        begin c.ex_jump = 1'b1; c.rw = rt; end
      OP_JAL, OP_JALR:    begin c.ex_jump = 1'b1; c.jal = 1'b1; c.regwrite = 1'b1; c.rw = 5'd31; end
      OP_BEQZ, OP_BNEZ:   c.rw = rt;
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        c.mem2reg = 1'b1; c.alusrc = 1'b1; c.regwrite = 1'b1; c.rw = rt;
        c.dsize = mem_size(op); c.loadext = (op == OP_LB) || (op == OP_LH);
      end
      OP_SB, OP_SH, OP_SW: begin
        c.memwrite = 1'b1; c.alusrc = 1'b1; c.rw = rt; c.dsize = mem_size(op);
      end
`ifdef FPU_REGS_EN
      OP_LF: begin
        c.mem2reg = 1'b1; c.alusrc = 1'b1; c.regwrite = 1'b1; c.rw = rt;
        c.dsize = DS_WORD; c.fpoint = FILE_FP;
      end
      OP_SF: begin
        c.memwrite = 1'b1; c.alusrc = 1'b1; c.rw = rt; c.dsize = DS_WORD; c.fpoint = FILE_FP;
      end
`endif
      default: if (i_ok) begin
        c.alusrc = 1'b1; c.regwrite = 1'b1; c.aluctrl = i_alu; c.rw = rt;
      end
    endcase
  end

  // Immediate: logical ops zero-extend, lhi places imm16 in the upper half.
  always_comb begin
    case (op)
      OP_ANDI, OP_ORI, OP_XORI: imm = {16'h0, bus.instruction[15:0]};
      OP_LHI:                   imm = {bus.instruction[15:0], 16'h0};
      default:                  imm = sext16(bus.instruction[15:0]);
    endcase
  end

  // Early branch/jump resolution from the forwarded A operand.
  always_comb begin
    case (op)
      OP_J, OP_JAL:    tgt = bus.delayslot + {{6{bus.instruction[25]}}, bus.instruction[25:0]};
      OP_JR, OP_JALR:  tgt = opa;
      default:         tgt = bus.delayslot + sext16(bus.instruction[15:0]);
    endcase
  end

  assign bus.branch       = ((op == OP_BEQZ) && (opa == '0)) || ((op == OP_BNEZ) && (opa != '0));
  assign bus.jump         = (op == OP_J) || (op == OP_JAL) || (op == OP_JR) || (op == OP_JALR);
  assign bus.jar          = (op == OP_JR) || (op == OP_JALR);
  assign bus.branchtarget = tgt;

  // ID/EX register: reset inserts a bubble and overrides stall.
  always_ff @(posedge clock) begin
    if (reset) begin
      ins_q <= '0; ds2_q <= '0; imm_q <= '0; a_q <= '0; b_q <= '0; ctrl_q <= '0;
    end else if (!bus.stall) begin
      ins_q <= bus.instruction; ds2_q <= bus.delayslot2_in; imm_q <= imm;
      a_q <= opa; b_q <= opb; ctrl_q <= c;
    end
  end

  assign bus.instruction_out = ins_q;
  assign bus.delayslot2_out  = ds2_q;
  assign bus.imm32           = imm_q;
  assign bus.busA            = a_q;
  assign bus.busB            = b_q;
  assign bus.regdst          = ctrl_q.regdst;
  assign bus.alusrc          = ctrl_q.alusrc;
  assign bus.mem2reg         = ctrl_q.mem2reg;
  assign bus.regwrite        = ctrl_q.regwrite;
  assign bus.memwrite        = ctrl_q.memwrite;
  assign bus.ex_jump         = ctrl_q.ex_jump;
  assign bus.loadext         = ctrl_q.loadext;
  assign bus.jal             = ctrl_q.jal;
  assign bus.aluctrl         = ctrl_q.aluctrl;
  assign bus.fpoint          = ctrl_q.fpoint;
  assign bus.dsize           = ctrl_q.dsize;
  assign bus.rw              = ctrl_q.rw;
endmodule

// File: tb/tb_reg_decode.sv
// Bench for reg_decode (default build, FPU_REGS_EN undefined): directed
// scenarios followed by random instructions against a table-driven model.
module tb_reg_decode;
  logic clock = 1'b0;
  logic reset = 1'b1;
  reg_decode_if bus();
  reg_decode dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;

  int n_pass = 0, n_chk = 0;
  logic [31:0] regs [32];
  int ftab [64];
  int itab [64];
  int ops [$] = '{0,0,0,1,2,3,4,4,5,5,8,9,10,11,12,13,14,15,18,19,20,22,23,24,25,26,27,28,29,
                  32,33,35,36,37,38,40,41,43,46,6,16,21,63};
  int fns [$] = '{32,33,34,35,36,37,38,4,6,7,40,41,42,43,44,45,0,5,39,63};
  logic [31:0] e_ins, e_ds2, e_imm, e_a, e_b;
  logic [20:0] e_ctrl;
  logic [31:0] ins_a, ins_b;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [20:0] got_ctrl();
    return {bus.regdst, bus.alusrc, bus.mem2reg, bus.regwrite, bus.memwrite, bus.ex_jump,
            bus.loadext, bus.jal, bus.aluctrl, bus.fpoint, bus.dsize, bus.rw};
  endfunction

  // Reference decode: ALU codes come from lookup tables, everything else
  // from opcode classes.
  function automatic logic [20:0] ref_ctrl(input logic [31:0] ins);
    int op, alu, ds;
    logic rdst, src, m2r, rwr, mw, ej, lx, lk;
    logic [4:0] dst;
    op = int'(ins[31:26]);
    {rdst, src, m2r, rwr, mw, ej, lx, lk} = 8'h0;
    dst = 5'd0; alu = 0; ds = 0;
    if (op <= 1) begin
      alu = ftab[ins[5:0]];
      if (alu >= 0) begin rdst = 1; rwr = 1; dst = ins[15:11]; end else alu = 0;
    end else if (op == 2 || op == 18) begin
      ej = 1; dst = ins[20:16];
    end else if (op == 3 || op == 19) begin
      ej = 1; lk = 1; rwr = 1; dst = 5'd31;
    end else if (op == 4 || op == 5) begin
      dst = ins[20:16];
    end else if (op inside {32, 33, 35, 36, 37, 40, 41, 43}) begin
      src = 1; dst = ins[20:16];
      ds = ((op - 32) % 4 == 3) ? 2 : (op - 32) % 4;
      if (op < 40) begin m2r = 1; rwr = 1; lx = (op <= 33); end else mw = 1;
    end else begin
      alu = itab[op];
      if (alu >= 0) begin src = 1; rwr = 1; dst = ins[20:16]; end else alu = 0;
    end
    return {rdst, src, m2r, rwr, mw, ej, lx, lk, 4'(alu), 2'b00, 2'(ds), dst};
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] ins);
    int op;
    op = int'(ins[31:26]);
    if (op >= 12 && op <= 14) return {16'h0, ins[15:0]};
    if (op == 15) return {ins[15:0], 16'h0};
    return {{16{ins[15]}}, ins[15:0]};
  endfunction

  function automatic logic [31:0] rd_model(input logic [4:0] r);
    if (r == 5'd0) return 32'h0;
    if (bus.wrenable && bus.wb_fpoint == 2'b00 && bus.wb_rw == r) return bus.busW;
    return regs[r];
  endfunction

  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] v);
    if (sel == 2'b01) return bus.aluout;
    if (sel == 2'b10) return bus.dmemout;
    return v;
  endfunction

  task automatic check_regs();
    chk("ins_out", bus.instruction_out, e_ins);
    chk("ds2_out", bus.delayslot2_out, e_ds2);
    chk("imm32", bus.imm32, e_imm);
    chk("busA", bus.busA, e_a);
    chk("busB", bus.busB, e_b);
    chk("ctrl", got_ctrl(), e_ctrl);
  endtask

  // One clock: settle, check the combinational outputs, advance the model,
  // then check the ID/EX register after the edge.
  task automatic step(input logic rst, input logic stl, input bit do_chk);
    logic [31:0] ins, a, b, tgt, ds;
    logic br, jp, jr;
    int op;
    reset = rst; bus.stall = stl;
    #1;
    ins = bus.instruction; ds = bus.delayslot; op = int'(ins[31:26]);
    a = fwd(bus.fwdA, rd_model(ins[25:21]));
    b = fwd(bus.fwdB, rd_model(ins[20:16]));
    br = (op == 4 && a == 0) || (op == 5 && a != 0);
    jp = op inside {2, 3, 18, 19};
    jr = op inside {18, 19};
    if (op == 2 || op == 3) tgt = ds + {{6{ins[25]}}, ins[25:0]};
    else if (jr)            tgt = a;
    else                    tgt = ds + {{16{ins[15]}}, ins[15:0]};
    if (do_chk) chk("comb", {bus.branch, bus.jump, bus.jar, bus.branchtarget}, {br, jp, jr, tgt});
    if (rst) begin
      e_ins = 0; e_ds2 = 0; e_imm = 0; e_a = 0; e_b = 0; e_ctrl = 0;
    end else if (!stl) begin
      e_ins = ins; e_ds2 = bus.delayslot2_in; e_imm = ref_imm(ins);
      e_a = a; e_b = b; e_ctrl = ref_ctrl(ins);
    end
    if (bus.wrenable && bus.wb_fpoint == 2'b00 && bus.wb_rw != 5'd0) regs[bus.wb_rw] = bus.busW;
    @(posedge clock); #1;
    if (do_chk) check_regs();
  endtask

  task automatic idle();
    bus.wrenable = 0; bus.wb_fpoint = 0; bus.wb_rw = 0; bus.busW = 0;
    bus.fwdA = 0; bus.fwdB = 0; bus.aluout = 0; bus.dmemout = 0;
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] v);
    bus.wrenable = 1; bus.wb_fpoint = 0; bus.wb_rw = r; bus.busW = v;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin ftab[i] = -1; itab[i] = -1; end
    ftab[32] = 0; ftab[33] = 0; ftab[34] = 1; ftab[35] = 1; ftab[36] = 2; ftab[37] = 3;
    ftab[38] = 4; ftab[4] = 5; ftab[6] = 6; ftab[7] = 7;
    for (int i = 0; i < 6; i++) begin ftab[40 + i] = 8 + i; itab[24 + i] = 8 + i; end
    itab[8] = 0; itab[9] = 0; itab[10] = 1; itab[11] = 1; itab[12] = 2; itab[13] = 3;
    itab[14] = 4; itab[15] = 14; itab[20] = 5; itab[22] = 6; itab[23] = 7;

    idle();
    bus.stall = 0; bus.instruction = 0; bus.delayslot = 0; bus.delayslot2_in = 0;

    // Reset state, then fill the register file while stalled (outputs hold 0).
    step(1, 0, 0);
    check_regs();
    for (int r = 1; r < 32; r++) begin
      wr(5'(r), $urandom);
      step(0, 1, 0);
    end
    check_regs();
    idle();

    // add r3,r5,r0 while r5 is written in the same cycle.
    wr(5'd5, 32'h12345678);
    bus.instruction = {6'd0, 5'd5, 5'd0, 5'd3, 5'd0, 6'd32};
    step(0, 0, 1);
    chk("t28_busA", bus.busA, 32'h12345678);
    chk("t28_rw", bus.rw, 3);
    chk("t28_alu", bus.aluctrl, 0);
    chk("t28_regwrite", bus.regwrite, 1);
    idle();

    // lw r2,8(r1) with A forwarded from EX.
    bus.instruction = {6'd35, 5'd1, 5'd2, 16'd8};
    bus.fwdA = 2'b01; bus.aluout = 32'h100;
    step(0, 0, 1);
    chk("t29_busA", bus.busA, 32'h100);
    chk("t29_imm", bus.imm32, 8);
    chk("t29_mem2reg", bus.mem2reg, 1);
    chk("t29_dsize", bus.dsize, 2);
    chk("t29_alusrc", bus.alusrc, 1);
    idle();

    // beqz r4,-4 with r4=0, then r4=1.
    wr(5'd4, 32'h0);
    bus.instruction = {6'd4, 5'd4, 5'd0, 16'hFFFC};
    bus.delayslot = 32'h40;
    step(0, 0, 1);
    chk("t30_branch", bus.branch, 1);
    chk("t30_target", bus.branchtarget, 32'h3C);
    wr(5'd4, 32'h1);
    step(0, 0, 1);
    idle(); #1;
    chk("t30_nobranch", bus.branch, 0);

    // jalr r7 with r7=0x200.
    wr(5'd7, 32'h200);
    bus.instruction = {6'd19, 5'd7, 21'd0};
    step(0, 0, 1);
    chk("t31_jump", bus.jump, 1);
    chk("t31_jar", bus.jar, 1);
    chk("t31_target", bus.branchtarget, 32'h200);
    chk("t31_rw", bus.rw, 31);
    chk("t31_jal", bus.jal, 1);
    idle();

    // Stall for two cycles with a new instruction waiting.
    ins_a = {6'd13, 5'd0, 5'd9, 16'h55};
    ins_b = {6'd8, 5'd1, 5'd10, 16'h7};
    bus.instruction = ins_a;
    step(0, 0, 1);
    bus.instruction = ins_b;
    step(0, 1, 1);
    chk("t32_hold1", bus.instruction_out, ins_a);
    step(0, 1, 1);
    chk("t32_hold2", bus.instruction_out, ins_a);
    step(0, 0, 1);
    chk("t32_load", bus.instruction_out, ins_b);

    // Reset (with stall) mid-stream; register contents survive.
    bus.instruction = {6'd0, 5'd5, 5'd0, 5'd3, 5'd0, 6'd32};
    step(1, 1, 1);
    chk("t33_busA", bus.busA, 0);
    chk("t33_ctrl", got_ctrl(), 0);
    chk("t33_ins", bus.instruction_out, 0);
    step(0, 0, 1);
    chk("t33_r5", bus.busA, 32'h12345678);

    // Random stream.
    for (int i = 0; i < 500; i++) begin
      logic [31:0] ins;
      int op;
      ins = $urandom;
      op = ops[$urandom_range(0, ops.size() - 1)];
      ins[31:26] = 6'(op);
      if (op <= 1) ins[5:0] = 6'(fns[$urandom_range(0, fns.size() - 1)]);
      bus.instruction   = ins;
      bus.delayslot     = $urandom;
      bus.delayslot2_in = $urandom;
      bus.wrenable      = 1'($urandom_range(0, 1));
      bus.wb_rw         = 5'($urandom);
      bus.busW          = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      bus.wb_fpoint     = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      bus.fwdA          = 2'($urandom);
      bus.fwdB          = 2'($urandom);
      bus.aluout        = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      bus.dmemout       = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      step(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 4) == 0), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
